// File: rtl/reg_file_multiport_if.sv
// Bus bundle for reg_file_multiport: one write port, READ_PORTS packed read ports
// and the committed-write counter.
interface reg_file_multiport_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                         we;
  logic [AW-1:0]                waddr;
  logic [WIDTH-1:0]             wdata;
  logic [READ_PORTS*AW-1:0]     raddr;
  logic [READ_PORTS*WIDTH-1:0]  rdata;
  logic [15:0]                  wr_count;

  modport master (
    output we, waddr, wdata, raddr,
    input  rdata, wr_count
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    output rdata, wr_count
  );
endinterface

// File: rtl/reg_file_multiport.sv
// Multi-read-port flip-flop register file with an optional hard-wired zero register
// and a saturating write counter. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module reg_file_multiport #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_file_multiport_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_r      [DEPTH];
  logic [15:0]       wr_count_r;
  logic              commit_s;
  logic [AW-1:0]     rd_addr_s  [READ_PORTS];
  logic [WIDTH-1:0]  rd_data_s  [READ_PORTS];
  logic [READ_PORTS*WIDTH-1:0] rdata_s;

  // A write commits unless it targets the hard-wired zero register.
  always_comb begin
    commit_s = 1'b0;
    if (bus.we && !((ZERO_REG != 0) && (bus.waddr == {AW{1'b0}}))) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Storage array; reset wipes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (commit_s) begin
      mem_r[bus.waddr] <= bus.wdata;
    end else begin
      mem_r[bus.waddr] <= mem_r[bus.waddr];
    end
  end

  // Saturating count of committed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_r <= 16'h0000;
    end else if (commit_s && (wr_count_r != 16'hFFFF)) begin
      wr_count_r <= wr_count_r + 16'h0001;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  // Independent combinational read ports; zero register overrides any forwarding.
  always_comb begin
    rdata_s = {(READ_PORTS*WIDTH){1'b0}};
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr_s[p] = bus.raddr[p*AW +: AW];
      rd_data_s[p] = mem_r[rd_addr_s[p]];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && commit_s && (rd_addr_s[p] == bus.waddr)) begin
        rd_data_s[p] = bus.wdata;
      end else begin
        rd_data_s[p] = mem_r[rd_addr_s[p]];
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr_s[p] == {AW{1'b0}})) begin
        rd_data_s[p] = {WIDTH{1'b0}};
      end else begin
        rd_data_s[p] = rd_data_s[p];
      end
      rdata_s[p*WIDTH +: WIDTH] = rd_data_s[p];
    end
  end

  assign bus.rdata    = rdata_s;
  assign bus.wr_count = wr_count_r;

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed self-checking bench for reg_file_multiport (3 read ports, ZERO_REG=1);
// bypass expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_multiport;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_multiport_if #(.WIDTH(32), .DEPTH(32), .READ_PORTS(3)) bus ();

  reg_file_multiport #(
    .WIDTH(32), .DEPTH(32), .READ_PORTS(3), .ZERO_REG(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input int p);
    return bus.rdata[p*32 +: 32];
  endfunction

  task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.raddr = {a2, a1, a0};
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_raddr(5'd5, 5'd7, 5'd31);
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rd(p) !== 32'h0) begin
        errors++; $display("FAIL reset_rdata p%0d: got %h expected %h", p, rd(p), 32'h0);
      end
    end
    checks++;
    if (bus.wr_count !== 16'h0) begin
      errors++; $display("FAIL reset_wr_count: got %h expected %h", bus.wr_count, 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_write(5'd5, 32'hDEADBEEF);
    set_raddr(5'd5, 5'd6, 5'd0);
    #1;
    checks++;
    if (rd(0) !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pre_reset_read: got %h expected %h", rd(0), 32'hDEADBEEF);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd(0) !== 32'h0) begin
      errors++; $display("FAIL async_reset_rdata: got %h expected %h", rd(0), 32'h0);
    end
    checks++;
    if (bus.wr_count !== 16'h0) begin
      errors++; $display("FAIL async_reset_wr_count: got %h expected %h", bus.wr_count, 16'h0);
    end
    // A write presented during reset must be ignored.
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h66666666;
    @(posedge clk);
    #1;
    checks++;
    if ((bus.wr_count !== 16'h0) || (rd(1) !== 32'h0)) begin
      errors++; $display("FAIL write_in_reset: got cnt %h data %h expected cnt %h data %h",
                         bus.wr_count, rd(1), 16'h0, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    checks++;
    if ((bus.wr_count !== 16'h1) || (rd(1) !== 32'h66666666)) begin
      errors++; $display("FAIL first_write_after_reset: got cnt %h data %h expected cnt %h data %h",
                         bus.wr_count, rd(1), 16'h1, 32'h66666666);
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    do_write(5'd7, 32'h12345678);
    set_raddr(5'd7, 5'd7, 5'd7);
    #1;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rd(p) !== 32'h12345678) begin
        errors++; $display("FAIL write_read p%0d: got %h expected %h", p, rd(p), 32'h12345678);
      end
    end
    checks++;
    if (bus.wr_count !== 16'h1) begin
      errors++; $display("FAIL write_read_count: got %h expected %h", bus.wr_count, 16'h1);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    set_raddr(5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (rd(0) !== 32'h0) begin
      errors++; $display("FAIL zero_reg_same_cycle: got %h expected %h", rd(0), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (rd(p) !== 32'h0) begin
        errors++; $display("FAIL zero_reg_read p%0d: got %h expected %h", p, rd(p), 32'h0);
      end
    end
    checks++;
    if (bus.wr_count !== 16'h1) begin
      errors++; $display("FAIL zero_reg_count: got %h expected %h", bus.wr_count, 16'h1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00000001;
`endif
    do_write(5'd3, 32'h00000001);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
    set_raddr(5'd3, 5'd7, 5'd3);
    #1;
    checks++;
    if (rd(0) !== exp_same) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rd(0), exp_same);
    end
    checks++;
    if (rd(1) !== 32'h12345678) begin
      errors++; $display("FAIL bypass_other_port: got %h expected %h", rd(1), 32'h12345678);
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    checks++;
    if ((rd(0) !== 32'hA5A5A5A5) || (rd(2) !== 32'hA5A5A5A5)) begin
      errors++; $display("FAIL bypass_after_edge: got %h/%h expected %h",
                         rd(0), rd(2), 32'hA5A5A5A5);
    end
    checks++;
    if (bus.wr_count !== 16'h3) begin
      errors++; $display("FAIL bypass_count: got %h expected %h", bus.wr_count, 16'h3);
    end
  endtask

  task automatic test_ports();
    do_write(5'd1, 32'h11);
    do_write(5'd2, 32'h22);
    do_write(5'd3, 32'h33);
    set_raddr(5'd3, 5'd1, 5'd2);
    #1;
    checks++;
    if ((rd(0) !== 32'h33) || (rd(1) !== 32'h11) || (rd(2) !== 32'h22)) begin
      errors++; $display("FAIL independent_ports: got %h/%h/%h expected %h/%h/%h",
                         rd(0), rd(1), rd(2), 32'h33, 32'h11, 32'h22);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'hCAFE0001;
    set_raddr(5'd1, 5'd2, 5'd0);
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (bus.wr_count !== 16'hFFFE) begin
      errors++; $display("FAIL count_fffe: got %h expected %h", bus.wr_count, 16'hFFFE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_ffff: got %h expected %h", bus.wr_count, 16'hFFFF);
    end
    repeat (5) @(posedge clk);
    #1;
    bus.we = 1'b0;
    checks++;
    if (bus.wr_count !== 16'hFFFF) begin
      errors++; $display("FAIL count_saturated: got %h expected %h", bus.wr_count, 16'hFFFF);
    end
    checks++;
    if ((rd(0) !== 32'hCAFE0001) || (rd(1) !== 32'h0)) begin
      errors++; $display("FAIL saturation_data: got %h/%h expected %h/%h",
                         rd(0), rd(1), 32'hCAFE0001, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.we = 1'b0;
    bus.waddr = 5'd0;
    bus.wdata = 32'h0;
    bus.raddr = 15'h0;
    test_reset();
    test_async_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_ports();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
